dilithium_input_adapter: RTL and testbench
==========================================

# dilithium_input_adapter

Streams a host-supplied operand of known length into the Dilithium core. It sits between the external 64-bit valid/ready input port and the core's input handshake, and is the upstream counterpart of the output adapter. It loads a word count on `start`, accepts exactly that many words through a 2-entry skid buffer, and presents them to the core with registered outputs. It then pulses `done`, and optionally checks the host's `last` framing.

## Interface
- `w`, 64, data word width.
- `LEN_W`, 10, width of the word-count port; supports up to 1023 words.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; loads `in_len` and begins a transfer.
- `in_len`  in  LEN_W  number of words to transfer; sampled only when `start`=1.
- `valid_i`  in  1  host word valid.
- `ready_i`  out  1  adapter accepts host word.
- `data_i`  in  w  host data word.
- `last_i`  in  1  host marks final word.
- `dilithium_valid_i`  out  1  word available to core.
- `dilithium_ready_i`  in  1  core accepts word.
- `dilithium_data_i`  out  w  word to core.
- `done`  out  1  one-cycle pulse when the final word has been accepted by the core.
- `error`  out  1  sticky framing error (see Configuration).

## Operation
- A transfer is a beat on a side where valid and ready are both 1 on the same edge.
- FSM states:
  - IDLE: `ready_i`=0; `start` goes to STREAM, or to FINISH if `in_len`=0.
  - STREAM: `ready_i` = (skid count < 2) and (`remaining` != 0). Each host beat writes to the skid buffer and decrements `remaining`. When `remaining` reaches 0, go to DRAIN.
  - DRAIN: `ready_i`=0; when the skid buffer is empty, go to FINISH.
  - FINISH: `done`=1 for one cycle, then IDLE.
- Skid buffer:
  - 2 entries, FIFO order.
  - `dilithium_valid_i` = (count != 0).
  - `dilithium_data_i` = head entry, registered; it never changes while valid=1 and ready=0.
- Simultaneous host beat and core beat with count=2 cannot happen, because `ready_i`=0 when count=2.
  - With count=1, both happen and count stays 1.
  - With count=0, a write makes valid=1 on the next cycle; there is no combinational bypass.
- `remaining` is an LEN_W-bit down-counter. It never wraps: decrement is gated by `remaining` != 0.
- `start` in any non-IDLE state aborts the transfer:
  - the skid buffer is flushed;
  - `error` is cleared;
  - the counter is reloaded and the FSM enters STREAM (or FINISH if `in_len`=0);
  - no `done` is produced for the aborted transfer.
- `rst` has priority over `start`.
- Reset and IDLE values: `ready_i`=0, `dilithium_valid_i`=0, `dilithium_data_i`=0, `done`=0, `error`=0, skid count=0, FSM=IDLE.

## Timing
- Host beat at edge N makes the word visible to the core after edge N (cycle N+1); latency is 1 cycle.
- Full throughput of 1 word/cycle while the core holds `dilithium_ready_i`=1.
- `ready_i` is a function of registered state only; there is no combinational path from `dilithium_ready_i` to `ready_i`.
- `done` is asserted in the cycle after the core beat that emptied the buffer in DRAIN.
- `in_len`=0: `done` is asserted in the cycle after `start`.

## Configuration
- Macro: `DILITHIUM_IN_LAST_CHECK_EN`.
- Defined, `last_i` is checked on every host beat:
  - `last_i`=1 with `remaining`>1: set `error`, force `remaining`:=0, go to DRAIN. Already-buffered words still go to the core, and `done` still pulses.
  - `last_i`=0 on the beat where `remaining`=1: set `error`; the transfer completes normally.
  - `error` holds until `rst` or `start`.
- Undefined: `last_i` is ignored and `error` is tied to 0.

## Test plan
- `in_len`=4, host and core always ready, data 1..4 -> core receives 1,2,3,4 on consecutive cycles starting 1 cycle after the first host beat; `done` pulses once 1 cycle after the last core beat; `error`=0.
- `in_len`=6, core ready deasserted for 5 cycles mid-stream -> `ready_i` drops once 2 words are buffered; data is held stable; order is preserved; no loss or duplication; `done` pulses once.
- `in_len`=0 -> no beats on either side; `done`=1 exactly one cycle after `start`.
- `start` with `in_len`=8, then a second `start` with `in_len`=3 after 5 host beats -> buffer flushed, 3 new words delivered, single `done`; `rst` asserted mid-stream -> all outputs return to reset values next cycle.
- With `DILITHIUM_IN_LAST_CHECK_EN` defined, `in_len`=5 and `last_i` on beat 3 -> `error`=1; 3 words reach the core; `done` pulses; `ready_i` stays 0 afterwards.
- With `DILITHIUM_IN_LAST_CHECK_EN` defined, `in_len`=5 and no `last_i` -> `error`=1; 5 words are delivered. With the macro undefined, the same stimulus gives `error`=0.

Source files
------------

// File: rtl/dilithium_input_adapter.sv
// Host-to-core input adapter: counted 64-bit stream through a 2-entry skid buffer.
// Optional host `last` framing check enabled by defining DILITHIUM_IN_LAST_CHECK_EN.
module dilithium_input_adapter #(
    parameter int unsigned w     = 64,
    parameter int unsigned LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] in_len,
    input  logic             valid_i,
    output logic             ready_i,
    input  logic [w-1:0]     data_i,
    input  logic             last_i,
    output logic             dilithium_valid_i,
    input  logic             dilithium_ready_i,
    output logic [w-1:0]     dilithium_data_i,
    output logic             done,
    output logic             error
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [w-1:0]     head_q, head_d;
    logic [w-1:0]     tail_q, tail_d;
    logic             push, pop;
    logic             early_last;

    assign ready_i           = (state_q == STREAM) && (cnt_q != 2'd2) && (rem_q != '0);
    assign dilithium_valid_i = (cnt_q != 2'd0);
    assign dilithium_data_i  = head_q;
    assign done              = (state_q == FINISH);

    assign push = valid_i & ready_i;
    assign pop  = dilithium_valid_i & dilithium_ready_i;

    // Vacated entries are zeroed so the core-side data reads 0 whenever the buffer is empty.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = data_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = data_i;
                end else if (push) begin
                    tail_d = data_i;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    head_d = '0;
                    cnt_d  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    tail_d = '0;
                    cnt_d  = 2'd1;
                end
            end
            default: begin
                cnt_d = 2'd0;
            end
        endcase
        if (start) begin
            cnt_d  = 2'd0;
            head_d = '0;
            tail_d = '0;
        end
    end

`ifdef DILITHIUM_IN_LAST_CHECK_EN
    logic err_q, err_d;
    logic late_last;

    assign early_last = push && last_i && (rem_q > LEN_ONE);
    assign late_last  = push && !last_i && (rem_q == LEN_ONE);

    always_comb begin
        err_d = err_q;
        if (early_last || late_last) begin
            err_d = 1'b1;
        end
        if (start) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error = err_q;
`else
    logic unused_last;

    assign unused_last = last_i;
    assign early_last  = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
            end
            STREAM: begin
                if (push) begin
                    // push implies rem_q != 0, so this never wraps
                    rem_d = rem_q - LEN_ONE;
                    if (early_last) begin
                        rem_d = '0;
                    end
                    if (rem_d == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Look at the next count so done follows the emptying core beat by one cycle.
                if (cnt_d == 2'd0) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start) begin
            rem_d   = in_len;
            state_d = (in_len == '0) ? FINISH : STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_dilithium_input_adapter.sv
// Scoreboard bench for dilithium_input_adapter: host beats queue expected words,
// a forked monitor pops and compares on every core beat.
module tb_dilithium_input_adapter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  in_len;
    logic        valid_i;
    logic        ready_i;
    logic [63:0] data_i;
    logic        last_i;
    logic        dilithium_valid_i;
    logic        dilithium_ready_i;
    logic [63:0] dilithium_data_i;
    logic        done;
    logic        error;

    dilithium_input_adapter #(.w(64), .LEN_W(10)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .in_len            (in_len),
        .valid_i           (valid_i),
        .ready_i           (ready_i),
        .data_i            (data_i),
        .last_i            (last_i),
        .dilithium_valid_i (dilithium_valid_i),
        .dilithium_ready_i (dilithium_ready_i),
        .dilithium_data_i  (dilithium_data_i),
        .done              (done),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DILITHIUM_IN_LAST_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    int          checks = 0;
    int          fails  = 0;
    logic [63:0] exp_q[$];
    int          host_total = 0;
    int          core_total = 0;
    int          done_total = 0;
    int          first_host = -1;
    int          first_core = -1;
    int          last_core  = -1;
    int          done_cyc   = -1;
    int          start_cyc  = -1;
    bit          saw_full   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic start_xfer(input int unsigned len);
        @(posedge clk);
        #1;
        in_len  = 10'(len);
        start   = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer words base, base+1, ... until n host beats complete; core ready follows the stall window.
    task automatic send_words(input int n, input logic [63:0] base, input int last_at,
                              input int stall_at, input int stall_n, input int timeout);
        int beats = 0;
        int c = 0;
        while (beats < n && c < timeout) begin
            valid_i           = 1'b1;
            data_i            = base + 64'(beats);
            last_i            = (beats + 1 == last_at);
            dilithium_ready_i = !(c >= stall_at && c < stall_at + stall_n);
            @(negedge clk);
            if (valid_i && ready_i) beats++;
            @(posedge clk);
            #1;
            c++;
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        chk("host_beats_within_budget", 64'(beats), 64'(n));
    endtask

    task automatic wait_done(input int timeout);
        int d0 = done_total;
        int c = 0;
        while (done_total == d0 && c < timeout) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("done_within_budget", 64'(done_total != d0), 64'd1);
    endtask

    int h0, c0, d0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_len = '0;
        valid_i = 1'b0;
        data_i = '0;
        last_i = 1'b0;
        dilithium_ready_i = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    exp_q.delete();
                    prev_stall = 1'b0;
                end else begin
                    chk("core_valid_vs_occupancy", 64'(dilithium_valid_i), 64'(exp_q.size() != 0));
                    if (exp_q.size() >= 2) begin
                        saw_full = 1'b1;
                        chk("ready_low_when_full", 64'(ready_i), 64'd0);
                    end
                    if (prev_stall && dilithium_valid_i)
                        chk("data_held_while_stalled", dilithium_data_i, prev_data);
                    if (dilithium_valid_i && dilithium_ready_i) begin
                        core_total++;
                        last_core = cyc;
                        if (first_core < 0) first_core = cyc;
                        chk("core_beat_has_expected_word", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) chk("core_data", dilithium_data_i, exp_q.pop_front());
                    end
                    if (valid_i && ready_i) begin
                        exp_q.push_back(data_i);
                        host_total++;
                        if (first_host < 0) first_host = cyc;
                    end
                    if (done) begin
                        done_total++;
                        done_cyc = cyc;
                    end
                    prev_stall = dilithium_valid_i && !dilithium_ready_i;
                    prev_data  = dilithium_data_i;
                    if (start) begin
                        exp_q.delete();
                        prev_stall = 1'b0;
                        start_cyc  = cyc;
                        first_host = -1;
                        first_core = -1;
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ready_i), 64'd0);
        chk("rst_valid", 64'(dilithium_valid_i), 64'd0);
        chk("rst_data", dilithium_data_i, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: 4 words, both sides always ready
        h0 = host_total; c0 = core_total; d0 = done_total;
        start_xfer(4);
        send_words(4, 64'd1, 0, 0, 0, 20);
        wait_done(20);
        #1;
        chk("t1_core_words", 64'(core_total - c0), 64'd4);
        chk("t1_latency", 64'(first_core), 64'(first_host + 1));
        chk("t1_consecutive", 64'(last_core), 64'(first_core + 3));
        chk("t1_done_timing", 64'(done_cyc), 64'(last_core + 1));
        chk("t1_error", 64'(error), 64'd0);
        @(negedge clk);
        chk("t1_done_single", 64'(done_total - d0), 64'd1);

        // T2: 6 words, core stalls 5 cycles mid-stream
        c0 = core_total; d0 = done_total; saw_full = 1'b0;
        start_xfer(6);
        send_words(6, 64'hA0, 0, 2, 5, 40);
        dilithium_ready_i = 1'b1;
        wait_done(20);
        repeat (2) @(negedge clk);
        chk("t2_core_words", 64'(core_total - c0), 64'd6);
        chk("t2_buffer_filled", 64'(saw_full), 64'd1);
        chk("t2_done_single", 64'(done_total - d0), 64'd1);

        // T3: zero-length transfer, host offers data anyway
        h0 = host_total; c0 = core_total; d0 = done_total;
        start_xfer(0);
        valid_i = 1'b1;
        data_i  = 64'hDEAD;
        wait_done(5);
        #1;
        chk("t3_done_timing", 64'(done_cyc), 64'(start_cyc + 1));
        repeat (3) @(negedge clk);
        valid_i = 1'b0;
        chk("t3_no_host_beats", 64'(host_total - h0), 64'd0);
        chk("t3_no_core_beats", 64'(core_total - c0), 64'd0);
        chk("t3_done_single", 64'(done_total - d0), 64'd1);

        // T4: abort a len-8 transfer after 5 host beats with one word still buffered
        c0 = core_total; d0 = done_total;
        start_xfer(8);
        send_words(5, 64'h10, 0, 3, 3, 40);
        dilithium_ready_i = 1'b0;
        start_xfer(3);
        dilithium_ready_i = 1'b1;
        send_words(3, 64'h100, 0, 0, 0, 20);
        wait_done(20);
        repeat (2) @(negedge clk);
        chk("t4_core_words", 64'(core_total - c0), 64'd7);
        chk("t4_done_single", 64'(done_total - d0), 64'd1);

        // T5: last_i on beat 3 of 5
        c0 = core_total; d0 = done_total; h0 = host_total;
        start_xfer(5);
        if (CHECK_EN) send_words(3, 64'h200, 3, 0, 0, 20);
        else          send_words(5, 64'h200, 3, 0, 0, 20);
        wait_done(20);
        @(negedge clk);
        chk("t5_error", 64'(error), 64'(CHECK_EN));
        chk("t5_core_words", 64'(core_total - c0), CHECK_EN ? 64'd3 : 64'd5);
        chk("t5_done_single", 64'(done_total - d0), 64'd1);
        valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_ready_stays_low", 64'(ready_i), 64'd0);
        end
        valid_i = 1'b0;

        // T6: 5 words without last_i; start clears any sticky error
        c0 = core_total; d0 = done_total;
        start_xfer(5);
        @(negedge clk);
        chk("t6_error_cleared", 64'(error), 64'd0);
        @(posedge clk);
        #1;
        send_words(5, 64'h300, 0, 0, 0, 20);
        wait_done(20);
        @(negedge clk);
        chk("t6_error", 64'(error), 64'(CHECK_EN));
        chk("t6_core_words", 64'(core_total - c0), 64'd5);

        // T7: reset mid-stream, with start asserted alongside reset
        d0 = done_total;
        start_xfer(8);
        send_words(2, 64'h400, 0, 0, 100, 20);
        @(negedge clk);
        chk("t7_valid_before_rst", 64'(dilithium_valid_i), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        in_len = 10'd5;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        dilithium_ready_i = 1'b1;
        valid_i = 1'b1;
        @(negedge clk);
        chk("t7_ready", 64'(ready_i), 64'd0);
        chk("t7_valid", 64'(dilithium_valid_i), 64'd0);
        chk("t7_data", dilithium_data_i, 64'd0);
        chk("t7_done", 64'(done), 64'd0);
        chk("t7_error", 64'(error), 64'd0);
        @(negedge clk);
        chk("t7_stays_idle", 64'(ready_i), 64'd0);
        valid_i = 1'b0;
        chk("t7_no_done", 64'(done_total - d0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
